// File: rtl/mac_tile_ctrl.sv
// -----------------------------------------------------------------------------
// mac_tile_ctrl
//
// Sequencing controller for one output tile of the mac8-based systolic array.
// It accepts a job descriptor (reduction depth k), issues the array-wide
// synchronous clear, and gates the accumulate enable on each accepted operand
// beat. It then runs a fixed drain of D = 2*(DIM-1) cycles so the skewed
// wavefront reaches the last PE. Finally it presents the finished tile together
// with a sticky saturation summary.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   abort                     synchronous job abort (ignored in IDLE)
//   start_valid/start_ready   job descriptor handshake, cfg_k sampled on it
//   cfg_k                     reduction depth, legal range 1..K_MAX
//   err_cfg                   one-cycle pulse after a rejected descriptor
//   in_valid/in_ready         operand beat handshake on the array edge
//   drain_zero                feeder must drive zero operands (drain phase)
//   mac_clr, mac_en           array-wide clear / accumulate enable
//   sat_any                   OR of all PE saturation flags
//   res_valid/res_ready       completed tile handshake
//   res_sat                   some PE saturated during this job
//   busy                      controller is not idle
// -----------------------------------------------------------------------------
module mac_tile_ctrl #(
    parameter int DIM   = 8,
    parameter int K_MAX = 64,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [KW-1:0] cfg_k,
    output logic          err_cfg,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          drain_zero,
    output logic          mac_clr,
    output logic          mac_en,
    input  logic          sat_any,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_sat,
    output logic          busy
);

    // Drain length and the width of its down-counter (at least one bit).
    localparam int D        = 2 * (DIM - 1);
    localparam int DCW      = (D > 0) ? $clog2(D + 1) : 1;
    localparam int D_LOAD_I = (D > 0) ? (D - 1) : 0;
    localparam logic [DCW-1:0] D_LOAD = DCW'(D_LOAD_I);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic            sat_q, sat_d;
    logic            err_q, err_d;

    logic            cfg_bad_s;
    logic            beat_s;
    logic            last_beat_s;

    // Descriptor legality and beat decode.
    always_comb begin
        cfg_bad_s   = (cfg_k == {KW{1'b0}}) || (cfg_k > KW'(K_MAX));
        beat_s      = (state_q == S_FEED) && in_valid;
        last_beat_s = beat_s && (beat_q == (k_q - KW'(1)));
    end

    // Next-state and counter logic; abort overrides every transition at the end.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        sat_d   = sat_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (cfg_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = cfg_k;
                        state_d = S_CLEAR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CLEAR: begin
                // The array is being cleared this cycle: start a fresh job record.
                sat_d   = 1'b0;
                beat_d  = {KW{1'b0}};
                state_d = S_FEED;
            end

            S_FEED: begin
                sat_d = sat_q | sat_any;
                if (beat_s) begin
                    beat_d = beat_q + KW'(1);
                    if (last_beat_s) begin
                        drain_d = D_LOAD;
                        // A 1x1 array has no skew, so there is nothing to drain.
                        state_d = (D == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        state_d = S_FEED;
                    end
                end else begin
                    state_d = S_FEED;
                end
            end

            S_DRAIN: begin
                sat_d = sat_q | sat_any;
                if (drain_q == {DCW{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end

            S_DONE: begin
                // Keep sampling here: PE saturation flags are registered and lag
                // the last enable by a cycle.
                sat_d = sat_q | sat_any;
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= {KW{1'b0}};
            beat_q  <= {KW{1'b0}};
            drain_q <= {DCW{1'b0}};
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    // Output decodes. Every output is forced low while rst is asserted, even in
    // the first reset cycle before the state register has been cleared.
    always_comb begin
        start_ready = !rst && (state_q == S_IDLE);
        err_cfg     = !rst && err_q;
        in_ready    = !rst && (state_q == S_FEED);
        drain_zero  = !rst && (state_q == S_DRAIN);
        mac_clr     = !rst && (state_q == S_CLEAR);
        mac_en      = !rst && (((state_q == S_FEED) && in_valid) || (state_q == S_DRAIN));
        res_valid   = !rst && (state_q == S_DONE);
        res_sat     = !rst && (state_q == S_DONE) && (sat_q || sat_any);
        busy        = !rst && (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mac_tile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_tile_ctrl: directed bench for mac_tile_ctrl with DIM=4 (D=6), K_MAX=64.
// A cycle-by-cycle vector table covers the basic job, rejected descriptors and
// a stalled feed; hand-written sequences cover reset, k=K_MAX, result hold,
// saturation timing and abort.
// -----------------------------------------------------------------------------
module tb_mac_tile_ctrl;

    localparam int KW = 7;

    logic          clk;
    logic          rst;
    logic          abort;
    logic          start_valid;
    logic          start_ready;
    logic [KW-1:0] cfg_k;
    logic          err_cfg;
    logic          in_valid;
    logic          in_ready;
    logic          drain_zero;
    logic          mac_clr;
    logic          mac_en;
    logic          sat_any;
    logic          res_valid;
    logic          res_ready;
    logic          res_sat;
    logic          busy;
    logic [8:0]    outs_s;

    int checks   = 0;
    int failures = 0;

    mac_tile_ctrl #(.DIM(4), .K_MAX(64), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .abort       (abort),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_k       (cfg_k),
        .err_cfg     (err_cfg),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .drain_zero  (drain_zero),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .sat_any     (sat_any),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sat     (res_sat),
        .busy        (busy)
    );

    // {start_ready, err_cfg, in_ready, drain_zero, mac_clr, mac_en, res_valid, res_sat, busy}
    assign outs_s = {start_ready, err_cfg, in_ready, drain_zero, mac_clr,
                     mac_en, res_valid, res_sat, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          sv;
        logic [KW-1:0] cfg;
        logic          iv;
        logic          sat;
        logic          rr;
        logic          ab;
        logic [8:0]    exp;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic sv, input logic [KW-1:0] cfg, input logic iv,
                        input logic sat, input logic rr, input logic ab,
                        input logic [8:0] exp);
        vec_t v;
        v.sv = sv; v.cfg = cfg; v.iv = iv; v.sat = sat; v.rr = rr; v.ab = ab;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then move to the sampling point.
    task automatic drive(input logic sv, input logic [KW-1:0] cfg, input logic iv,
                         input logic sat, input logic rr, input logic ab);
        start_valid = sv; cfg_k = cfg; in_valid = iv;
        sat_any = sat; res_ready = rr; abort = ab;
        #4;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    int cnt_feed;
    int cnt_drain;
    int lat;
    int rv_cnt;
    logic seen;

    initial begin
        // ---------------- vector table ----------------
        // Job A: k=4, in_valid tied high, start at row 0.
        push(1'b1, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0, 9'b100000000);
        push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000010001);
        for (int c = 2; c <= 5; c++)
            push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b001001001);
        for (int c = 6; c <= 11; c++)
            push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b000101001);
        push(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9'b000000101);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);
        // Rejected descriptors: k=0 and k=65.
        push(1'b1, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);
        push(1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 9'b110000000);
        push(1'b1, 7'd65, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);
        push(1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 9'b110000000);
        push(1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);
        // Job B: k=3, in_valid 0,1,0,1,1; saturation pulse in the first DONE cycle.
        push(1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010001);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001000001);
        push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b001001001);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001000001);
        push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b001001001);
        push(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b001001001);
        for (int c = 7; c <= 12; c++)
            push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000101001);
        push(1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b000000111);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000111);
        push(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100000000);

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b1, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        adv();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("reset_outs%0d", c), 32'(outs_s), 32'd0);
            adv();
        end
        rst = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_outs", 32'(outs_s), 32'h100);
        adv();
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_no_clr", 32'(mac_clr), 32'd0);
        adv();

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].cfg, tbl[i].iv, tbl[i].sat, tbl[i].rr, tbl[i].ab);
            chk($sformatf("row%0d", i), 32'(outs_s), 32'(tbl[i].exp));
            adv();
        end

        // ---------------- k = K_MAX ----------------
        drive(1'b1, 7'd64, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("kmax_accept", 32'(start_ready), 32'd1);
        adv();
        cnt_feed = 0; cnt_drain = 0; lat = 1; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (res_valid) begin
                seen = 1'b1;
            end else begin
                if (mac_en && in_ready) cnt_feed++;
                if (mac_en && drain_zero) cnt_drain++;
                lat++;
                adv();
            end
        end
        chk("kmax_done_seen", 32'(seen), 32'd1);
        chk("kmax_feed_en", 32'(cnt_feed), 32'd64);
        chk("kmax_drain_en", 32'(cnt_drain), 32'd6);
        chk("kmax_latency", 32'(lat), 32'd72);
        res_ready = 1'b1;
        adv();
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("kmax_back_idle", 32'(start_ready), 32'd1);
        adv();

        // ---------------- sat in last DRAIN cycle, result held 5 cycles ----------------
        for (int c = 0; c <= 16; c++) begin
            drive(c == 0, 7'd2, 1'b1, c == 9, c == 15, 1'b0);
            if (c == 9) chk("hold_last_drain", 32'(drain_zero), 32'd1);
            if (c >= 10 && c <= 14) begin
                chk($sformatf("hold_valid%0d", c), 32'(res_valid), 32'd1);
                chk($sformatf("hold_sat%0d", c), 32'(res_sat), 32'd1);
                chk($sformatf("hold_sready%0d", c), 32'(start_ready), 32'd0);
            end
            if (c == 16) chk("hold_back_idle", 32'(start_ready), 32'd1);
            adv();
        end

        // ---------------- next job without saturation ----------------
        for (int c = 0; c <= 10; c++) begin
            drive(c == 0, 7'd1, 1'b1, 1'b0, c == 9, 1'b0);
            if (c == 9) begin
                chk("clean_valid", 32'(res_valid), 32'd1);
                chk("clean_sat", 32'(res_sat), 32'd0);
            end
            if (c == 10) chk("clean_idle", 32'(start_ready), 32'd1);
            adv();
        end

        // ---------------- abort mid-FEED after 2 beats ----------------
        for (int c = 0; c <= 5; c++) begin
            drive(c == 0, 7'd5, 1'b1, 1'b0, 1'b0, c == 4);
            if (c == 4) chk("abort_in_feed", 32'(in_ready), 32'd1);
            if (c == 5) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_sready", 32'(start_ready), 32'd1);
            end
            adv();
        end
        rv_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            if (res_valid || mac_en) rv_cnt++;
            adv();
        end
        chk("abort_no_result", 32'(rv_cnt), 32'd0);
        drive(1'b1, 7'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        adv();
        drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("abort_fresh_clr", 32'(mac_clr), 32'd1);
        adv();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            adv();
        end
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
